// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: sequencer op codes, ALU control codes
// and the sequencer state encoding.
package cpu_pkg;

   typedef enum logic [1:0] {
      OP_MUL = 2'd0,
      OP_SHL = 2'd1,
      OP_SHR = 2'd2,
      OP_SAR = 2'd3
   } op_t;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_XOR = 4'd2;
   localparam logic [3:0] ALU_AND = 4'd3;
   localparam logic [3:0] ALU_INC = 4'd4;
   localparam logic [3:0] ALU_DEC = 4'd5;
   localparam logic [3:0] ALU_SHL = 4'd6;
   localparam logic [3:0] ALU_SHR = 4'd7;
   localparam logic [3:0] ALU_SAR = 4'd8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHIFT = 3'd1,
      ST_MADD  = 3'd2,
      ST_MDBL  = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/alu.sv
// 16-bit single-step ALU: one arithmetic, logic or one-position shift per cycle.
module alu
   import cpu_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [3:0]  control,
   output logic [15:0] y,
   output logic        zero,
   output logic        sign
);

   always_comb begin
      y = 16'h0000;
      case (control)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_XOR: y = a ^ b;
         ALU_AND: y = a & b;
         ALU_INC: y = a + 16'd1;
         ALU_DEC: y = a - 16'd1;
         ALU_SHL: y = {a[14:0], 1'b0};
         ALU_SHR: y = {1'b0, a[15:1]};
         ALU_SAR: y = {a[15], a[15:1]};
         default: y = 16'h0000;
      endcase
   end

   assign zero = (y == 16'h0000);
   assign sign = y[15];

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle sequencer around the single-step ALU: shift-and-add multiply
// (low 16 bits) and 0-15 position shifts built from one-bit ALU shifts.
module alu_seq
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] y,
   output logic        zero,
   output logic        sign
);

   seq_state_t  st;
   op_t         opr;
   logic [15:0] acc;
   logic [15:0] m;
   logic [15:0] n;
   logic [3:0]  cnt;

   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [3:0]  alu_ctl;
   logic [15:0] alu_y;
   logic        alu_zero;
   logic        alu_sign;
   logic        unused_alu_flags;

   // Operand/control mux; idle states park the ALU on ADD 0+0.
   always_comb begin
      alu_a   = 16'h0000;
      alu_b   = 16'h0000;
      alu_ctl = ALU_ADD;
      case (st)
         ST_SHIFT: begin
            alu_a = acc;
            case (opr)
               OP_SHL:  alu_ctl = ALU_SHL;
               OP_SHR:  alu_ctl = ALU_SHR;
               OP_SAR:  alu_ctl = ALU_SAR;
               default: alu_ctl = ALU_ADD;
            endcase
         end
         ST_MADD: begin
            alu_a = acc;
            alu_b = m;
         end
         ST_MDBL: begin
            alu_a   = m;
            alu_ctl = ALU_SHL;
         end
         default: ;
      endcase
   end

   alu u_alu (
      .a       (alu_a),
      .b       (alu_b),
      .control (alu_ctl),
      .y       (alu_y),
      .zero    (alu_zero),
      .sign    (alu_sign)
   );

   assign unused_alu_flags = alu_zero ^ alu_sign;

   // y is loaded only on the edge that enters DONE, with the final acc value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st   <= ST_IDLE;
         opr  <= OP_MUL;
         acc  <= 16'h0000;
         m    <= 16'h0000;
         n    <= 16'h0000;
         cnt  <= 4'd0;
         y    <= 16'h0000;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (st)
            ST_IDLE: begin
               if (start) begin
                  opr  <= op_t'(op);
                  busy <= 1'b1;
                  if (op_t'(op) == OP_MUL) begin
                     acc <= 16'h0000;
                     m   <= a;
                     n   <= b;
                     if (b != 16'h0000) begin
                        st <= ST_MADD;
                     end else begin
                        st   <= ST_DONE;
                        y    <= 16'h0000;
                        done <= 1'b1;
                     end
                  end else begin
                     acc <= a;
                     cnt <= b[3:0];
                     if (b[3:0] != 4'd0) begin
                        st <= ST_SHIFT;
                     end else begin
                        st   <= ST_DONE;
                        y    <= a;
                        done <= 1'b1;
                     end
                  end
               end
            end
            ST_SHIFT: begin
               acc <= alu_y;
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  st   <= ST_DONE;
                  y    <= alu_y;
                  done <= 1'b1;
               end
            end
            ST_MADD: begin
               if (n[0]) acc <= alu_y;
               st <= ST_MDBL;
            end
            ST_MDBL: begin
               m <= alu_y;
               n <= n >> 1;
               if (n[15:1] == 15'd0) begin
                  st   <= ST_DONE;
                  y    <= acc;
                  done <= 1'b1;
               end else begin
                  st <= ST_MADD;
               end
            end
            ST_DONE: begin
               st   <= ST_IDLE;
               busy <= 1'b0;
            end
            default: begin
               st   <= ST_IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

   assign zero = (y == 16'h0000);
   assign sign = y[15];

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized bench for alu_seq against an arithmetic reference.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] y;
   logic        zero;
   logic        sign;

   int tests = 0;
   int fails = 0;

   alu_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .y     (y),
      .zero  (zero),
      .sign  (sign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: result and done cycle from the arithmetic definition.
   function automatic logic [15:0] ref_y(input logic [1:0] o, input logic [15:0] x, input logic [15:0] z);
      int k;
      k = int'(z[3:0]);
      case (o)
         2'd0:    return 16'((32'(x) * 32'(z)) % 65536);
         2'd1:    return 16'(x << k);
         2'd2:    return 16'(x >> k);
         default: return 16'($signed(x) >>> k);
      endcase
   endfunction

   function automatic int ref_lat(input logic [1:0] o, input logic [15:0] z);
      int hi;
      if (o != 2'd0) return int'(z[3:0]) + 1;
      hi = 0;
      for (int i = 0; i < 16; i++) if (z[i]) hi = i + 1;
      return (hi == 0) ? 1 : 2 * hi + 1;
   endfunction

   // Issue one op; glitch > 0 pulses a stray SHL start in that cycle.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                         input logic [15:0] z, input int glitch);
      logic [15:0] ey;
      int          elat;
      int          lat;
      logic        busy_ok;
      ey      = ref_y(o, x, z);
      elat    = ref_lat(o, z);
      lat     = -1;
      busy_ok = 1'b1;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = z;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
      for (int j = 1; j <= 40; j++) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            lat = j;
            break;
         end
         if (j == glitch) begin
            start = 1'b1; op = 2'd1; a = 16'($urandom);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      check({tag, " done_cycle"}, 32'(lat), 32'(elat));
      check({tag, " busy"}, 32'(busy_ok), 32'd1);
      check({tag, " y"}, 32'(y), 32'(ey));
      check({tag, " zero"}, 32'(zero), 32'(ey == 16'h0000));
      check({tag, " sign"}, 32'(sign), 32'(ey[15]));
      @(posedge clk); #1;
      check({tag, " done_pulse"}, {30'd0, busy, done}, 32'd0);
      check({tag, " y_hold"}, 32'(y), 32'(ey));
   endtask

   initial begin
      logic [1:0]  ro;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        saw_done;

      reset = 1'b1; start = 1'b0; op = 2'd0; a = 16'h0000; b = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset y", 32'(y), 32'd0);
      check("reset flags", {30'd0, zero, sign}, 32'd2);
      @(negedge clk);
      reset = 1'b0;

      run_op("mul_small", 2'd0, 16'd3, 16'd5, 0);
      run_op("mul_ovf", 2'd0, 16'h0100, 16'h0100, 0);
      run_op("sar", 2'd3, 16'h8000, 16'd4, 0);
      run_op("shr15", 2'd2, 16'h8000, 16'h00FF, 0);
      run_op("shl0", 2'd1, 16'h0001, 16'h0000, 0);
      run_op("mul_b0", 2'd0, 16'h1234, 16'h0000, 0);
      run_op("mul_busy", 2'd0, 16'd7, 16'hFFFF, 5);

      // Reset in cycle 4 of a multiply: immediate clear, no done afterwards.
      @(negedge clk);
      start = 1'b1; op = 2'd0; a = 16'd9; b = 16'hF000;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rst_mid busy", 32'(busy), 32'd0);
      check("rst_mid y", 32'(y), 32'd0);
      check("rst_mid zero", 32'(zero), 32'd1);
      check("rst_mid done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      check("rst_mid quiet", 32'(saw_done), 32'd0);
      run_op("after_rst", 2'd0, 16'd11, 16'd13, 0);

      for (int t = 0; t < 40; t++) begin
         ro = 2'($urandom_range(0, 3));
         ra = 16'($urandom);
         rb = 16'($urandom) >> $urandom_range(0, 16);
         run_op($sformatf("rnd%0d", t), ro, ra, rb, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
